data_mem_responder: RTL

//  Memory-side responder for the core's data-memory req/gnt/rvalid interface; the target that the
//  LSU's data_* ports connect to. Holds a word-addressed SRAM array with byte-enable writes.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - data-memory req/gnt/rvalid bus between an initiator (master) and the memory responder (slave)
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data RAM responder, fixed-latency rvalid; DATA_MEM_STALL_EN adds LFSR-driven grant stalls
module data_mem_responder #(
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          RD_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    data_mem_responder_if.slave bus
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic                  stall;
    logic                  gnt;
    logic                  accept;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic [31:0]           offset;
    logic [AW-1:0]         idx;
    logic [1:0]            unused_addr_lsbs;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] s0_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  rd_q;
    logic [RD_LATENCY-1:0] vld_q;
    logic [RD_LATENCY-1:0] err_q;

`ifdef DATA_MEM_STALL_EN
    logic [7:0] lfsr_q;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR; bit 0 decides the stall of the current cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Address relative to the window base; the byte offset within a word is don't-care.
    assign offset           = bus.addr - BASE_ADDR;
    assign in_range         = ({2'b00, offset[31:2]} < 32'(MEM_WORDS));
    assign idx              = offset[AW+1:2];
    assign unused_addr_lsbs = offset[1:0];

    // Grant is gated by reset so nothing is accepted while the pipeline is being cleared.
    assign gnt     = bus.req & ~stall & rst_ni;
    assign bus.gnt = gnt;
    assign accept  = bus.req & gnt;
    assign wr_en   = accept & bus.we & in_range;
    assign rd_en   = accept & ~bus.we & in_range;

    // Array port: byte-enabled write and registered read, both on the accept edge (read-first).
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[idx];
        end
    end

    // Response control pipeline: valid/err shift one stage per cycle; rd_q qualifies the RAM output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept & ~in_range;
            rd_q     <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    // The RAM register is not reset, so it only reaches the data path for an in-range read.
    assign s0_data = rd_q ? ram_q : '0;

    if (RD_LATENCY > 1) begin : g_data_pipe
        logic [DATA_WIDTH-1:0] dat_q [1:RD_LATENCY-1];

        // Data stages behind the RAM register; bubbles and writes carry zero.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 1; i < RD_LATENCY; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                dat_q[1] <= s0_data;
                for (int i = 2; i < RD_LATENCY; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign out_data = dat_q[RD_LATENCY-1];
    end else begin : g_no_data_pipe
        assign out_data = s0_data;
    end

    assign bus.rvalid = vld_q[RD_LATENCY-1];
    assign bus.err    = vld_q[RD_LATENCY-1] & err_q[RD_LATENCY-1];
    assign bus.rdata  = vld_q[RD_LATENCY-1] ? out_data : '0;
endmodule
